// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Write-posting buffer between the processor data port and the single-port
//   dmem syncram. Stores are queued in a small circular FIFO and drained to
//   dmem on every cycle without a load. Loads that hit a queued store are
//   answered from the buffer, so the processor always sees its latest store.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   proc_address          load/store word address
//   proc_data             store data
//   proc_wren, proc_rden  store / load request
//   proc_q                load result, valid the cycle after proc_rden
//   stall                 store refused this cycle (buffer full)
//   flush                 drain request (draining already happens whenever
//                         possible; empty reports completion)
//   empty, full           buffer status
//   dmem_address/data/wren  to dmem
//   dmem_q                from dmem, one-cycle read latency
//
// Handshake: a store is taken on every edge where proc_wren=1 and stall=0.
// While stall=1 the processor must hold proc_address/proc_data/proc_wren
// unchanged; stall depends only on proc_wren and the registered full flag.
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] proc_address,
    input  logic [DATA_W-1:0] proc_data,
    input  logic              proc_wren,
    input  logic              proc_rden,
    output logic [DATA_W-1:0] proc_q,
    output logic              stall,
    input  logic              flush,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_data,
    output logic              dmem_wren,
    input  logic [DATA_W-1:0] dmem_q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              hit_q;
    logic [DATA_W-1:0] fwd_q;

    logic              push;
    logic              pop;
    logic              match;
    logic [DATA_W-1:0] match_data;
    logic [PTR_W-1:0]  idx;
    logic              flush_unused;

    // flush needs no logic of its own: the buffer drains on every non-load cycle.
    assign flush_unused = flush;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign stall = proc_wren && full;

    // A full buffer refuses a push even if the head leaves in the same cycle.
    assign push = proc_wren && !full;
    // Loads own the RAM port; draining only uses cycles without a load.
    assign pop  = !proc_rden && !empty;

    // dmem port mux. pop is deliberately not gated by reset: the head entry
    // being written at a reset edge still reaches dmem.
    always_comb begin
        dmem_address = proc_address;
        dmem_data    = '0;
        dmem_wren    = 1'b0;
        if (pop) begin
            dmem_address = addr_mem[head];
            dmem_data    = data_mem[head];
            dmem_wren    = 1'b1;
        end
    end

    // Walk entries oldest to youngest so the youngest match wins. Only entries
    // present at the start of the cycle are searched, so a same-cycle store
    // never forwards to a same-cycle load.
    always_comb begin
        match      = 1'b0;
        match_data = '0;
        idx        = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_mem[idx] == proc_address)) begin
                match      = 1'b1;
                match_data = data_mem[idx];
            end
        end
    end

    assign proc_q = hit_q ? fwd_q : dmem_q;

    // Entry storage carries no reset; validity comes from head/count.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[tail] <= proc_address;
            data_mem[tail] <= proc_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            hit_q <= 1'b0;
            fwd_q <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            hit_q <= proc_rden && match;
            if (proc_rden && match) fwd_q <= match_data;
        end
    end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Write-posting buffer between the processor's data-memory port and the `dmem` syncram. Processor stores are queued in a small FIFO and drained to `dmem` on cycles when the processor is not loading, so a store never competes with a load for the single-port RAM. Loads whose address matches a queued store are served from the buffer, so the processor always sees the latest store to that address. Both sides run on one clock, and the block is inserted on the processor-to-`dmem` path in the top level.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries (power of two, ≥2)
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, data width

Ports:
- clock  in  1  single clock for the block; `dmem` samples on the same edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- proc_address  in  ADDR_W  load/store address from processor
- proc_data  in  DATA_W  store data
- proc_wren  in  1  store request
- proc_rden  in  1  load request
- proc_q  out  DATA_W  load result, valid the cycle after proc_rden
- stall  out  1  store not accepted this cycle; processor must hold the request
- flush  in  1  request a full drain (level)
- empty  out  1  buffer holds no entries
- full  out  1  buffer holds DEPTH entries
- dmem_address  out  ADDR_W  to dmem
- dmem_data  out  DATA_W  to dmem
- dmem_wren  out  1  to dmem
- dmem_q  in  DATA_W  from dmem, 1-cycle read latency

## Operation
- Storage: circular FIFO of {addr, data}, with head/tail pointers of log2(DEPTH) bits (wrap modulo DEPTH) and a count of log2(DEPTH)+1 bits.
- Push: proc_wren && !full → write entry at tail, advance tail, and set count +1. If proc_wren && full, then stall=1 and nothing is pushed.
- Drain (pop): !proc_rden && !empty → drive dmem_address/dmem_data from the head entry, set dmem_wren=1, advance head, and set count −1. A load always wins the port, so there is no drain on a proc_rden cycle.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- A push while full is refused even if a pop occurs in the same cycle. stall is combinational: proc_wren && full.
- Load: proc_rden → dmem_address=proc_address and dmem_wren=0. In the same cycle, search all valid entries for an address match.
  - Match: register the data of the youngest match (closest to tail) and set hit_q=1.
  - No match: set hit_q=0.
  - Next cycle: proc_q = hit_q ? fwd_q : dmem_q.
- Forwarding searches only entries present at the start of the cycle. A store and a load issued in the same cycle never forward to each other, so the load returns the older value.
- When neither a load nor a drain is in progress: dmem_address=proc_address, dmem_data=0, dmem_wren=0.
- flush: no extra behaviour beyond draining on every non-load cycle. empty signals completion, and the processor halts loads until empty=1.
- Status outputs: empty = (count==0), full = (count==DEPTH).

## Timing
- Reset (synchronous, highest priority): head=tail=count=0, hit_q=0, fwd_q=0. Outputs after reset: empty=1, full=0, stall=0, dmem_wren=0, dmem_data=0, proc_q=dmem_q.
- Reset during a drain: the entry being written at that edge is still presented to dmem at that edge. All remaining entries are discarded.
- Latency from push to visibility:
  - Forwarding is visible to loads issued from cycle t+1.
  - An entry reaches dmem at the earliest at cycle t+1, or later behind older entries and load cycles.
- Load latency is one cycle, whether the data comes from a hit or from dmem.
- With a continuous stream of loads, nothing drains. A full buffer then stalls stores indefinitely, which is legal and has no timeout.
- Throughput: at most one push and one pop per cycle.

## Test plan
- Reset, then stores to addr 0x010=0xAAAA0001 and 0x011=0xAAAA0002 with proc_rden=0 → count reaches 1 and never exceeds 1. dmem_wren pulses twice, in order. empty=1 two cycles after the last store.
- Hold proc_rden=1 (address 0x3FF, with dmem_q driven to 0xDEADBEEF on the following cycles) while storing DEPTH+1 words → full=1 after DEPTH pushes and stall=1 on the extra push. Release rden → stall=0 and the held store is accepted.
- With proc_rden=1 held so entries stay queued, store 0x020=0x11111111 then 0x020=0x22222222, then load 0x020 → proc_q=0x22222222 the next cycle, independent of dmem_q.
- Load 0x030 (not buffered), with dmem preloaded 0x0BADF00D → proc_q=0x0BADF00D one cycle later.
- Store 0x040=0x12345678 and load 0x040 in the same cycle → proc_q=old dmem contents. A load of 0x040 on the next cycle → 0x12345678.
- Fill 3 entries, assert reset for one cycle → empty=1, count=0, dmem_wren=0 afterward. Subsequent loads of those addresses return dmem_q.
